// File: rtl/rr_arbiter_4_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
//   NUM_REQ  - number of requesters
//   IDX_W    - width of a requester index
//   state_e  - arbiter FSM state encoding
//   rr_pick  - rotating-priority search starting at a pointer
package rr_arbiter_4_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Returns {found, index}: the first set request in the order
  // ptr, ptr+1, ptr+2, ptr+3 (mod 4). The loop walks from the farthest
  // candidate to the nearest so the nearest one is the last to overwrite.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                             input logic [IDX_W-1:0]   ptr);
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cand;
    found = 1'b0;
    idx   = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + IDX_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/rr_arbiter_4_onehot_dec_2x4.sv
// 2-to-4 one-hot decoder with enable.
//   idx_i    - binary index
//   en_i     - when low the output is all zeros
//   onehot_o - one-hot decode of idx_i
module onehot_dec_2x4
  import rr_arbiter_4_pkg::*;
(
  input  logic [IDX_W-1:0]   idx_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[idx_i] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with release strobe and hold limit.
//   clk       - clock, all state updates on the rising edge
//   rst       - synchronous reset, active-high
//   req       - request lines, req[i] belongs to requester i
//   done      - owner release strobe, ignored while idle
//   gnt       - one-hot grant, decoded from the registered owner index
//   gnt_id    - binary index of the current owner
//   gnt_valid - a grant is active
//   timeout   - one-cycle pulse after a grant is revoked by the hold limit
//
// state    | meaning
// ---------+--------------------------------------------
// ST_IDLE  | no owner, grant on the first edge with any req
// ST_GRANT | gnt_id owns the resource, hold_cnt counts held cycles
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_id,
  output logic               gnt_valid,
  output logic               timeout
);

  // Last hold count before the limit forces a release.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);
  localparam logic             LIMIT_EN  = (HOLD_MAX != 0);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gnt_id_q, gnt_id_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  logic             rel_done;
  logic             rel_drop;
  logic             rel_limit;
  logic             release_now;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] search_ptr;
  logic [IDX_W:0]   pick;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  always_comb begin
    rel_done    = done;
    rel_drop    = ~req[gnt_id_q];
    rel_limit   = LIMIT_EN && (hold_cnt_q == HOLD_LAST);
    release_now = (state_q == ST_GRANT) && (rel_done || rel_drop || rel_limit);
    next_ptr    = gnt_id_q + 1'b1;
    // On release the search must already use the advanced pointer so the
    // releasing owner is last in line at this very edge.
    search_ptr  = release_now ? next_ptr : ptr_q;
    pick        = rr_pick(req, search_ptr);
    pick_found  = pick[IDX_W];
    pick_idx    = pick[IDX_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    hold_cnt_d  = hold_cnt_q;

    case (state_q)
      ST_IDLE: begin
        hold_cnt_d = '0;
        if (pick_found) begin
          state_d     = ST_GRANT;
          gnt_id_d    = pick_idx;
          gnt_valid_d = 1'b1;
        end
      end

      ST_GRANT: begin
        if (release_now) begin
          ptr_d      = next_ptr;
          timeout_d  = rel_limit && !rel_done && !rel_drop;
          hold_cnt_d = '0;
          if (pick_found) begin
            gnt_id_d    = pick_idx;
            gnt_valid_d = 1'b1;
          end else begin
            state_d     = ST_IDLE;
            gnt_valid_d = 1'b0;
          end
        end else if (LIMIT_EN && (hold_cnt_q != {CNT_W{1'b1}})) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        gnt_valid_d = 1'b0;
        hold_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  // gnt is a pure decode of flops, so it changes with gnt_id in the same cycle
  // and is forced to zero whenever no grant is active.
  onehot_dec_2x4 u_dec (
    .idx_i    (gnt_id_q),
    .en_i     (gnt_valid_q),
    .onehot_o (gnt)
  );

  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule
